// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the first low pulse of a 0x55 sync character on rx
// (50 MHz sampling) and classifies it as 2400/4800/9600/19200 bps on br_choice.
// Optional build macro AUTOBAUD_VERIFY_EN: require two consecutive low pulses
// of the same class before locking.
module uart_autobaud #(
    parameter logic [15:0] T_MIN  = 16'd1302,
    parameter logic [15:0] T_19_9 = 16'd3906,
    parameter logic [15:0] T_9_4  = 16'd7812,
    parameter logic [15:0] T_4_2  = 16'd15625,
    parameter logic [15:0] T_MAX  = 16'd31250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       start,
    output logic [1:0] br_choice,
    output logic       locked,
    output logic       error,
    output logic       busy
);

`ifdef AUTOBAUD_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, DONE, ERR, GAP, MEASURE2} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, DONE, ERR} state_t;
`endif

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [1:0]  br_n;
    logic        locked_n, error_n, busy_n;
    logic        rx_meta, rx_s, rx_d;
    logic        fall_p, rise_p;
    logic [2:0]  cls;   // {out_of_range, rate_code}
`ifdef AUTOBAUD_VERIFY_EN
    logic [1:0]  cls1, cls1_n;
`endif

    // Width classification; a width equal to a threshold falls to the slower rate.
    function automatic logic [2:0] classify(input logic [15:0] w);
        if (w < T_MIN || w > T_MAX) classify = 3'b100;
        else if (w < T_19_9)        classify = 3'b011;
        else if (w < T_9_4)         classify = 3'b010;
        else if (w < T_4_2)         classify = 3'b001;
        else                        classify = 3'b000;
    endfunction

    // Two-flop synchronizer, third copy for edge detection, registered edge pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            fall_p  <= 1'b0;
            rise_p  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            fall_p  <= rx_d & ~rx_s;
            rise_p  <= ~rx_d & rx_s;
        end
    end

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign cls     = classify(cnt);

    // State, width counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            br_choice <= 2'b11;
            locked    <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
`ifdef AUTOBAUD_VERIFY_EN
            cls1      <= 2'b00;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            br_choice <= br_n;
            locked    <= locked_n;
            error     <= error_n;
            busy      <= busy_n;
`ifdef AUTOBAUD_VERIFY_EN
            cls1      <= cls1_n;
`endif
        end
    end

    // Next-state logic; the edge pulses are aligned with rx_d, which is the level counted.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        br_n    = br_choice;
`ifdef AUTOBAUD_VERIFY_EN
        cls1_n  = cls1;
`endif
        case (state)
            IDLE: ;
            WAIT_IDLE: if (rx_d) state_n = WAIT_FALL;
            WAIT_FALL: if (fall_p) begin
                cnt_n   = 16'd1;
                state_n = MEASURE;
            end
            MEASURE: begin
                if (rise_p) begin
                    if (cls[2]) state_n = ERR;
                    else begin
`ifdef AUTOBAUD_VERIFY_EN
                        cls1_n  = cls[1:0];
                        cnt_n   = 16'd0;
                        state_n = GAP;
`else
                        br_n    = cls[1:0];
                        state_n = DONE;
`endif
                    end
                end else if (!rx_d) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc > T_MAX) state_n = ERR;   // stuck-low timeout
                end
            end
`ifdef AUTOBAUD_VERIFY_EN
            GAP: begin
                if (fall_p) begin
                    cnt_n   = 16'd1;
                    state_n = MEASURE2;
                end else if (rx_d) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc > T_MAX) state_n = ERR;   // line idle too long between pulses
                end
            end
            MEASURE2: begin
                if (rise_p) begin
                    if (cls[2] || cls[1:0] != cls1) state_n = ERR;
                    else begin
                        br_n    = cls[1:0];
                        state_n = DONE;
                    end
                end else if (!rx_d) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc > T_MAX) state_n = ERR;
                end
            end
`endif
            DONE: ;
            ERR:  ;
            default: state_n = IDLE;
        endcase
        // start wins over everything, including a classification in the same cycle.
        if (start) begin
            state_n = WAIT_IDLE;
            cnt_n   = 16'd0;
            br_n    = br_choice;
        end
        locked_n = (state_n == DONE);
        error_n  = (state_n == ERR);
        busy_n   = !(state_n == IDLE || state_n == DONE || state_n == ERR);
    end

endmodule
